// File: rtl/rnn_pkg.sv
// rnn_pkg: shared bank select codes, bank depths, data width and host FSM states
package rnn_pkg;
  localparam int DW = 20;
  localparam logic [2:0] MSEL_WX  = 3'b000;
  localparam logic [2:0] MSEL_BX  = 3'b001;
  localparam logic [2:0] MSEL_WH  = 3'b010;
  localparam logic [2:0] MSEL_BH  = 3'b011;
  localparam logic [2:0] MSEL_LEN = 3'b100;
  localparam logic [2:0] MSEL_OUT = 3'b101;
  localparam int WX_DEPTH = 2048;
  localparam int BX_DEPTH = 64;
  localparam int WH_DEPTH = 4096;
  localparam int BH_DEPTH = 64;
  typedef enum logic [1:0] {IDLE, REQ, RUN, DONE} state_t;
endpackage

// File: rtl/rnn_xqueue.sv
// rnn_xqueue: synchronous FIFO of 32-bit input vectors (clk, reset, push/din in, pop in, dout/full/empty out)
module rnn_xqueue #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [31:0] din,
  input  logic        pop,
  output logic [31:0] dout,
  output logic        full,
  output logic        empty
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_pop, do_push;
  assign full = cnt == DEPTH[AW:0];
  assign empty = cnt == '0;
  assign dout = mem[rp];
  assign do_pop = pop && !empty;
  // a pop on the same edge frees the slot, so a push into a full queue is still accepted
  assign do_push = push && (!full || do_pop);
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/rnn_host_responder.sv
// rnn_host_responder: host-side memory/input responder for the RNN core
// ports: core side (busy, ready, i_en, idata, mce, msel, maddr, mdata_w, mdata_r),
// host load (ld_*, x_push, x_data, x_full), control (start, done, x_underflow), readback (rd_*)
module rnn_host_responder #(
  parameter int OUT_AW = 12,
  parameter int XQ_DEPTH = 64,
  parameter int DW = rnn_pkg::DW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              busy,
  output logic              ready,
  input  logic              i_en,
  output logic [31:0]       idata,
  input  logic              mce,
  input  logic [2:0]        msel,
  input  logic [16:0]       maddr,
  input  logic [DW-1:0]     mdata_w,
  output logic [DW-1:0]     mdata_r,
  input  logic              ld_en,
  input  logic [2:0]        ld_sel,
  input  logic [16:0]       ld_addr,
  input  logic [DW-1:0]     ld_data,
  input  logic              x_push,
  input  logic [31:0]       x_data,
  output logic              x_full,
  input  logic              start,
  output logic              done,
  output logic              x_underflow,
  input  logic              rd_en,
  input  logic [OUT_AW-1:0] rd_addr,
  output logic [DW-1:0]     rd_data,
  output logic              rd_valid
);
  import rnn_pkg::*;
  logic [DW-1:0] wx [WX_DEPTH];
  logic [DW-1:0] bx [BX_DEPTH];
  logic [DW-1:0] wh [WH_DEPTH];
  logic [DW-1:0] bh [BH_DEPTH];
  logic [DW-1:0] ob [2**OUT_AW];
  logic [DW-1:0] seq_len, rdata;
  logic [31:0] x_head;
  logic x_empty, host_ok, ld_ok;
  state_t state;
  assign host_ok = state == IDLE || state == DONE;
  assign ld_ok = host_ok && ld_en;
  rnn_xqueue #(.DEPTH(XQ_DEPTH)) u_xq (
    .clk(clk), .reset(reset), .push(x_push), .din(x_data), .pop(i_en),
    .dout(x_head), .full(x_full), .empty(x_empty)
  );
  // host owns the parameter banks, the core owns the output bank
  always_ff @(posedge clk) if (ld_ok && ld_sel == MSEL_WX) wx[ld_addr[10:0]] <= ld_data;
  always_ff @(posedge clk) if (ld_ok && ld_sel == MSEL_BX) bx[ld_addr[5:0]] <= ld_data;
  always_ff @(posedge clk) if (ld_ok && ld_sel == MSEL_WH) wh[ld_addr[11:0]] <= ld_data;
  always_ff @(posedge clk) if (ld_ok && ld_sel == MSEL_BH) bh[ld_addr[5:0]] <= ld_data;
  always_ff @(posedge clk) if (ld_ok && ld_sel == MSEL_LEN && ld_addr == '0) seq_len <= ld_data;
  always_ff @(posedge clk) if (mce && msel == MSEL_OUT) ob[maddr[OUT_AW-1:0]] <= mdata_w;
  always_comb
    rdata = msel == MSEL_WX ? wx[maddr[10:0]] :
            msel == MSEL_BX ? bx[maddr[5:0]] :
            msel == MSEL_WH ? wh[maddr[11:0]] :
            msel == MSEL_BH ? bh[maddr[5:0]] :
            msel == MSEL_LEN && maddr == '0 ? seq_len : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      idata <= '0;
      mdata_r <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
      x_underflow <= 1'b0;
    end else begin
      if (mce && msel != MSEL_OUT) mdata_r <= rdata;
      if (i_en) idata <= x_empty ? '0 : x_head;
      if (i_en && x_empty) x_underflow <= 1'b1;
      rd_valid <= rd_en && host_ok;
      if (rd_en && host_ok) rd_data <= ob[rd_addr];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ready <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin state <= REQ; ready <= 1'b1; end
        REQ:  if (busy) begin state <= RUN; ready <= 1'b0; end
        RUN:  if (!busy) begin state <= DONE; done <= 1'b1; end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rnn_host_responder.sv
// tb_rnn_host_responder: scoreboard bench for rnn_host_responder
module tb_rnn_host_responder;
  localparam int DW = 20;
  localparam int S_MD = 0, S_ID = 1, S_UF = 2, S_RDY = 3, S_DN = 4, S_FL = 5, S_RV = 6;
  typedef struct {int cyc; int sig; logic [31:0] val; string name;} exp_t;
  logic clk = 0, reset = 1, busy = 0, i_en = 0, mce = 0, ld_en = 0, x_push = 0, start = 0, rd_en = 0;
  logic ready, done, x_full, x_underflow, rd_valid;
  logic [31:0] idata, x_data = 0;
  logic [2:0] msel = 0, ld_sel = 0;
  logic [16:0] maddr = 0, ld_addr = 0;
  logic [DW-1:0] mdata_w = 0, mdata_r, ld_data = 0, rd_data;
  logic [11:0] rd_addr = 0;
  int cyc = 0, checks = 0, errors = 0;
  exp_t sb[$];
  logic [DW-1:0] rdq[$];

  rnn_host_responder dut (
    .clk(clk), .reset(reset), .busy(busy), .ready(ready), .i_en(i_en), .idata(idata),
    .mce(mce), .msel(msel), .maddr(maddr), .mdata_w(mdata_w), .mdata_r(mdata_r),
    .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
    .x_push(x_push), .x_data(x_data), .x_full(x_full), .start(start), .done(done),
    .x_underflow(x_underflow), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sample(input int s);
    return s == S_MD ? 32'(mdata_r) : s == S_ID ? idata : s == S_UF ? 32'(x_underflow) :
           s == S_RDY ? 32'(ready) : s == S_DN ? 32'(done) : s == S_FL ? 32'(x_full) : 32'(rd_valid);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic [31:0] a;
    logic [DW-1:0] r;
    if (rd_valid) begin
      checks++;
      if (rdq.size() == 0) begin
        errors++;
        $display("FAIL rd_valid_unexpected cyc=%0d got rd_valid=1 want 0", cyc);
      end else begin
        r = rdq.pop_front();
        if (rd_data !== r) begin
          errors++;
          $display("FAIL rd_data cyc=%0d got %h want %h", cyc, rd_data, r);
        end
      end
    end
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      a = sample(e.sig);
      checks++;
      if (a !== e.val) begin
        errors++;
        $display("FAIL %s cyc=%0d got %h want %h", e.name, cyc, a, e.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int dly, input int sig, input logic [31:0] v, input string n);
    sb.push_back('{cyc + dly, sig, v, n});
  endtask

  task automatic load(input logic [2:0] s, input logic [16:0] a, input logic [DW-1:0] d);
    ld_en = 1; ld_sel = s; ld_addr = a; ld_data = d;
    step();
    ld_en = 0;
  endtask

  task automatic core_rd(input logic [2:0] s, input logic [16:0] a, input logic [DW-1:0] v, input string n);
    mce = 1; msel = s; maddr = a;
    chk(1, S_MD, 32'(v), n);
    step();
    mce = 0;
  endtask

  initial begin
    step(); step();
    chk(0, S_RDY, 0, "rst_ready"); chk(0, S_DN, 0, "rst_done"); chk(0, S_ID, 0, "rst_idata");
    chk(0, S_MD, 0, "rst_mdata"); chk(0, S_UF, 0, "rst_uflow"); chk(0, S_FL, 0, "rst_full");
    chk(0, S_RV, 0, "rst_rdvalid");
    reset = 0;
    step();
    // weight load and core read latency/hold
    load(3'b000, 17'h067, 20'h0ABCD);
    mce = 1; msel = 3'b000; maddr = 17'h067;
    chk(0, S_MD, 0, "wx_pre");
    chk(1, S_MD, 32'h0ABCD, "wx_read");
    step();
    mce = 0; maddr = 0;
    chk(1, S_MD, 32'h0ABCD, "wx_hold");
    step();
    // other banks, with address truncation
    load(3'b001, 17'h05, 20'h11111);
    load(3'b010, 17'hFFF, 20'h22222);
    load(3'b011, 17'h3F, 20'h33333);
    load(3'b000, 17'h0, 20'h00777);
    core_rd(3'b001, 17'h10045, 20'h11111, "bx_trunc");
    core_rd(3'b010, 17'h1FFFF, 20'h22222, "wh_trunc");
    core_rd(3'b011, 17'h0003F, 20'h33333, "bh_read");
    // seq_len register
    load(3'b100, 17'h0, 20'h00040);
    core_rd(3'b100, 17'h0, 20'h00040, "len_a0");
    core_rd(3'b100, 17'h1, 20'h0, "len_a1");
    core_rd(3'b100, 17'h0, 20'h00040, "len_a0b");
    core_rd(3'b110, 17'h0, 20'h0, "unused_sel");
    // input handshake
    x_push = 1; x_data = 32'hDEADBEEF; step();
    x_data = 32'h00000001; step();
    x_push = 0;
    i_en = 1; chk(1, S_ID, 32'hDEADBEEF, "idata_1"); step();
    i_en = 0; chk(1, S_ID, 32'hDEADBEEF, "idata_1_hold"); step();
    i_en = 1; chk(1, S_ID, 32'h1, "idata_2"); chk(1, S_UF, 0, "uflow_clear"); step();
    i_en = 0; step();
    i_en = 1; chk(1, S_ID, 0, "idata_under"); chk(1, S_UF, 1, "uflow_set"); step();
    i_en = 0; step();
    // start protocol with core traffic and blocked host load/readback during RUN
    start = 1; chk(1, S_RDY, 1, "ready_c0"); step();
    start = 0;
    for (int i = 0; i < 3; i++) begin
      chk(1, S_RDY, 1, "ready_wait"); step();
    end
    busy = 1; chk(1, S_RDY, 0, "ready_drop"); step();
    for (int i = 0; i < 9; i++) begin
      mce = (i == 2); msel = 3'b101; maddr = 17'h0041; mdata_w = 20'h1F000;
      ld_en = (i == 4); ld_sel = 3'b000; ld_addr = 0; ld_data = 20'h12345;
      rd_en = (i == 6); rd_addr = 12'h041;
      chk(1, S_DN, 0, "done_run"); chk(1, S_RDY, 0, "ready_run");
      step();
    end
    mce = 0; ld_en = 0; rd_en = 0;
    busy = 0; chk(1, S_DN, 1, "done_pulse"); step();
    chk(1, S_DN, 0, "done_clear"); chk(1, S_RDY, 0, "ready_idle"); step();
    rd_en = 1; rd_addr = 12'h041; rdq.push_back(20'h1F000);
    chk(1, S_RV, 1, "rdv_set"); step();
    rd_en = 0; chk(1, S_RV, 0, "rdv_clear"); step();
    core_rd(3'b000, 17'h0, 20'h00777, "wx0_kept");
    // queue fill, overflow drop, full push+pop
    for (int i = 0; i < 64; i++) begin
      x_push = 1; x_data = 32'h100 + 32'(i);
      chk(1, S_FL, 32'(i == 63), "fill_full");
      step();
    end
    x_data = 32'hBAD; chk(1, S_FL, 1, "full_drop"); step();
    x_data = 32'hCAFE; i_en = 1;
    chk(1, S_ID, 32'h100, "pop_push_full"); chk(1, S_FL, 1, "full_after_pp"); step();
    x_push = 0;
    for (int i = 1; i < 64; i++) begin
      chk(1, S_ID, 32'h100 + 32'(i), "drain"); step();
    end
    chk(1, S_ID, 32'hCAFE, "drain_last"); chk(1, S_FL, 0, "empty_full0"); step();
    i_en = 0;
    // reset during RUN
    x_push = 1; x_data = 32'h55; step(); x_data = 32'h66; step(); x_push = 0;
    start = 1; step(); start = 0;
    busy = 1; step(); step();
    reset = 1;
    chk(1, S_RDY, 0, "rrst_ready"); chk(1, S_DN, 0, "rrst_done"); chk(1, S_FL, 0, "rrst_full");
    chk(1, S_ID, 0, "rrst_idata"); chk(1, S_UF, 0, "rrst_uflow"); chk(1, S_MD, 0, "rrst_mdata");
    step();
    reset = 0; busy = 0;
    i_en = 1; chk(1, S_ID, 0, "flushed"); chk(1, S_UF, 1, "flushed_uflow"); step();
    i_en = 0;
    start = 1; chk(1, S_RDY, 1, "idle_after_rst"); step();
    start = 0; busy = 1; chk(1, S_RDY, 0, "ready_drop2"); step();
    busy = 0; chk(1, S_DN, 1, "done_pulse2"); step();
    chk(1, S_DN, 0, "done_clear2"); step();
    repeat (3) step();
    checks++;
    if (sb.size() != 0 || rdq.size() != 0) begin
      errors++;
      $display("FAIL pending got %0d/%0d want 0/0", sb.size(), rdq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rnn_host_responder.md
Name: rnn_host_responder

Overview:
- Host-side counterpart of the RNN core: answers the core's memory port (msel/maddr/mce/mdata_w/mdata_r) and its input-vector handshake (i_en/idata).
- Drives the ready/busy start protocol and gives the host a load port for weights, biases, sequence length and input vectors.
- Gives the host a readback port for the hidden-state outputs the core writes.
- Sits between the system host/testbench and the RNN core; the core connects to it directly.

Parameters:
- OUT_AW, 12, address width of output bank (default 64 steps × 64 hidden)
- XQ_DEPTH, 64, input-vector queue depth (power of 2)
- DW, 20, memory data width

Ports:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- busy  in  1  core busy
- ready  out  1  start request to core
- i_en  in  1  core requests next input vector
- idata  out  32  current input vector (1 bit per input feature)
- mce  in  1  core memory enable
- msel  in  3  bank select
- maddr  in  17  bank address
- mdata_w  in  DW  core write data
- mdata_r  out  DW  read data to core
- ld_en  in  1  host load strobe
- ld_sel  in  3  host load bank (same encoding as msel)
- ld_addr  in  17  host load address
- ld_data  in  DW  host load data
- x_push  in  1  push input vector
- x_data  in  32  vector to push
- x_full  out  1  queue full
- start  in  1  host start pulse
- done  out  1  one-cycle completion pulse
- x_underflow  out  1  sticky: i_en with empty queue
- rd_en  in  1  host output readback strobe
- rd_addr  in  OUT_AW  readback address
- rd_data  out  DW  readback data
- rd_valid  out  1  readback data valid

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clk.
- Reset values: ready=0, done=0, idata=0, mdata_r=0, rd_data=0, rd_valid=0, x_underflow=0, queue empty, FSM=IDLE. Memory contents are not cleared.
- Bank map:
  - 000: W_x, 2048 words, addr[10:0] = {h[5:0], i[4:0]}
  - 001: b_x, 64 words, addr[5:0]
  - 011: b_h, 64 words, addr[5:0]
  - 010: W_h, 4096 words, addr[11:0] = {h, j}
  - 100: seq_len register, addr 0 only; other addresses read 0
  - 101: output bank, write-only from core, addr[OUT_AW-1:0]
  - 110, 111: unused, read 0
- Core read path:
  - On a cycle with mce=1 and msel≠101, mdata_r <= bank[msel][maddr] on the next edge (1-cycle latency).
  - When mce=0, mdata_r holds its value.
  - Addresses are truncated to bank width.
- Core write path:
  - mce=1 and msel=101 → out_bank[maddr[OUT_AW-1:0]] <= mdata_w on that edge.
  - mdata_r holds on that cycle.
  - mdata_w with any other msel is ignored.
- Input handshake:
  - i_en=1 at edge n → idata <= queue head and the head is popped. idata is valid from cycle n+1 and holds until the next i_en.
  - i_en with an empty queue → idata <= 0 and x_underflow set (cleared only by reset).
- Queue:
  - x_push while not full enqueues x_data; a push while full is dropped.
  - Simultaneous push and pop on a full queue: the pop happens and the push is accepted.
  - x_full is combinational from the count.
- Host load:
  - ld_en is honoured only in IDLE or DONE and writes bank[ld_sel][ld_addr]; ignored in REQ/RUN.
  - ld_sel=100 writes seq_len.
  - ld_sel=101 is ignored.
- FSM (IDLE → REQ → RUN → DONE → IDLE):
  - IDLE: ready=0. start=1 → REQ.
  - REQ: ready=1. busy=1 → RUN, and ready drops in the same cycle as the transition register update.
  - RUN: ready=0. busy=0 → DONE.
  - DONE: done=1 for exactly one cycle → IDLE.
  - start outside IDLE is ignored.
  - reset in any state → IDLE within one edge; the queue is flushed and ready/done are forced to 0.
- Readback:
  - rd_en in IDLE/DONE → rd_data <= out_bank[rd_addr], rd_valid=1 the next cycle only.
  - rd_en in REQ/RUN → rd_valid stays 0.
- Core access and host load are never concurrent, so each bank has one write port muxed by FSM state.

Decomposition:
- Package rnn_pkg holds:
  - msel encodings (MSEL_WX=3'b000, MSEL_BX=3'b001, MSEL_WH=3'b010, MSEL_BH=3'b011, MSEL_LEN=3'b100, MSEL_OUT=3'b101)
  - bank depths
  - DW
  - FSM state enum
- One sub-module, rnn_xqueue: synchronous FIFO of 32-bit vectors with push/pop/full/empty. Banks stay as inline arrays.

Test Plan:
- Load W_x[{5'd3,5'd7}]=20'h0ABCD in IDLE; core-side mce=1, msel=000, maddr=0x067 → mdata_r=0x0ABCD exactly one cycle later; mce=0 next cycle → mdata_r holds 0x0ABCD.
- Push 0xDEADBEEF then 0x00000001; pulse i_en twice with one cycle between → idata=0xDEADBEEF the cycle after the first pulse, 0x00000001 after the second; third i_en → idata=0, x_underflow=1.
- start pulse; hold busy=0 for 3 cycles, then busy=1 for 10, then 0 → ready=1 for the first 4 cycles (until busy is seen), done=1 for exactly one cycle 1 edge after busy falls, then FSM is IDLE.
- During RUN, core writes mce=1, msel=101, maddr=0x0041, mdata_w=0x1F000; also ld_en to W_x addr 0 with 0x12345 → after DONE, rd_addr=0x041 gives rd_data=0x1F000 with rd_valid one cycle after rd_en; W_x[0] is unchanged.
- Fill the queue with XQ_DEPTH pushes → x_full=1; an extra push is dropped; assert reset in RUN → ready=0, done=0, queue empty, x_full=0, idata=0 next cycle.
- seq_len loaded 0x00040; core reads msel=100 maddr=0 → 0x00040; maddr=1 → 0; msel=110 → 0.
